// File: rtl/shifter_pkg.sv
// Shared types and constants for the sequential divide-by-2^N shifter.
package shifter_pkg;

  localparam int unsigned SH_WIDTH = 16;

  // Shift-amount width for a given operand width; never narrower than one bit.
  function automatic int unsigned sh_amt_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  typedef enum logic [1:0] {
    SH_IDLE,
    SH_SHIFT,
    SH_DONE
  } sh_state_e;

endpackage

// File: rtl/shifter_dividebytwo.sv
// Combinational one-bit right-shift stage; mirror of the multiply-by-two stage.
module shifter_dividebytwo #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  input  logic             fill,
  input  logic             enable,
  output logic [WIDTH-1:0] data_shifted,
  output logic             lsb_out
);

  always_comb begin
    data_shifted = data;
    lsb_out      = 1'b0;
    if (enable) begin
      data_shifted = {fill, data[WIDTH-1:1]};
      lsb_out      = data[0];
    end
  end

endmodule

// File: rtl/shifter_dividebypow2.sv
// Sequential right shifter: divides by 2^N at one bit per clock with carry/sticky.
// Arithmetic fill is available only when SHIFTER_ARITH_EN is defined.
module shifter_dividebypow2
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = SH_WIDTH,
  parameter int unsigned AMT_W = sh_amt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SH_START,
  input  logic [WIDTH-1:0] shift_in,
  input  logic [AMT_W-1:0] SH_AMT,
  input  logic             SH_ARITH,
  output logic [WIDTH-1:0] shift_out,
  output logic             carry_out,
  output logic             sticky_out,
  output logic             busy,
  output logic             done
);

  sh_state_e        state;
  logic [AMT_W-1:0] cnt;
  logic             fill;
  logic [WIDTH-1:0] stage_data;
  logic             stage_lsb;

`ifdef SHIFTER_ARITH_EN
  // Sign bit is resolved at accept time so the fill stays fixed for the whole op.
  logic fill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= 1'b0;
    end else if (SH_START && (state != SH_SHIFT)) begin
      fill_q <= SH_ARITH & shift_in[WIDTH-1];
    end
  end

  assign fill = fill_q;
`else
  logic unused_arith;
  assign unused_arith = SH_ARITH;
  assign fill         = 1'b0;
`endif

  shifter_dividebytwo #(
    .WIDTH (WIDTH)
  ) u_stage (
    .data         (shift_out),
    .fill         (fill),
    .enable       (state == SH_SHIFT),
    .data_shifted (stage_data),
    .lsb_out      (stage_lsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SH_IDLE;
      cnt        <= '0;
      shift_out  <= '0;
      carry_out  <= 1'b0;
      sticky_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        SH_IDLE, SH_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (SH_START) begin
            shift_out  <= shift_in;
            cnt        <= SH_AMT;
            carry_out  <= 1'b0;
            sticky_out <= 1'b0;
            if (SH_AMT != '0) begin
              state <= SH_SHIFT;
              busy  <= 1'b1;
            end else begin
              state <= SH_DONE;
              done  <= 1'b1;
            end
          end else begin
            state <= SH_IDLE;
          end
        end
        SH_SHIFT: begin
          shift_out  <= stage_data;
          carry_out  <= stage_lsb;
          sticky_out <= sticky_out | stage_lsb;
          cnt        <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state <= SH_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= SH_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_dividebypow2.sv
// Directed-vector bench for shifter_dividebypow2; expectations follow SHIFTER_ARITH_EN.
module tb_shifter_dividebypow2;

  localparam int unsigned W = 16;
  localparam int unsigned A = 4;

`ifdef SHIFTER_ARITH_EN
  localparam bit ARITH = 1'b1;
`else
  localparam bit ARITH = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         SH_START = 1'b0;
  logic [W-1:0] shift_in = '0;
  logic [A-1:0] SH_AMT = '0;
  logic         SH_ARITH = 1'b0;
  logic [W-1:0] shift_out;
  logic         carry_out;
  logic         sticky_out;
  logic         busy;
  logic         done;

  int n_vec = 0;
  int n_err = 0;

  shifter_dividebypow2 #(
    .WIDTH (W),
    .AMT_W (A)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .SH_START   (SH_START),
    .shift_in   (shift_in),
    .SH_AMT     (SH_AMT),
    .SH_ARITH   (SH_ARITH),
    .shift_out  (shift_out),
    .carry_out  (carry_out),
    .sticky_out (sticky_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] op;
    logic [A-1:0] amt;
    logic         arith;
    logic [W-1:0] exp_out;
    logic         exp_carry;
    logic         exp_sticky;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_start(input logic [W-1:0] op, input logic [A-1:0] amt, input logic arith);
    SH_START = 1'b1;
    shift_in = op;
    SH_AMT   = amt;
    SH_ARITH = arith;
  endtask

  // Caller is at a negedge with SH_START already driven; returns at the done negedge.
  task automatic wait_done(output int cyc, output int busy_cnt, output bit overlap);
    cyc      = 0;
    busy_cnt = 0;
    overlap  = 1'b0;
    @(negedge clk);
    SH_START = 1'b0;
    shift_in = 16'h5A5A;
    SH_AMT   = 4'hF;
    SH_ARITH = ~SH_ARITH;
    cyc = 1;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    if (busy && done) overlap = 1'b1;
  endtask

  task automatic run_op(input string name, input vec_t v);
    int cyc, bc;
    bit ov;
    @(negedge clk);
    drive_start(v.op, v.amt, v.arith);
    wait_done(cyc, bc, ov);
    check({name, " latency"}, cyc, int'(v.amt) + 1);
    check({name, " busy_cycles"}, bc, int'(v.amt));
    check({name, " busy_done_overlap"}, {31'd0, ov}, 32'd0);
    check({name, " shift_out"}, {16'd0, shift_out}, {16'd0, v.exp_out});
    check({name, " carry_out"}, {31'd0, carry_out}, {31'd0, v.exp_carry});
    check({name, " sticky_out"}, {31'd0, sticky_out}, {31'd0, v.exp_sticky});
    @(negedge clk);
    check({name, " done_single"}, {31'd0, done}, 32'd0);
    check({name, " hold"}, {16'd0, shift_out}, {16'd0, v.exp_out});
  endtask

  vec_t vecs[9];

  initial begin
    int cyc, bc, pulses;
    bit ov;
    logic [W-1:0] got;

    vecs[0] = '{16'h8001, 4'd1,  1'b0, 16'h4000, 1'b1, 1'b1};
    vecs[1] = '{16'h8000, 4'd15, 1'b1, ARITH ? 16'hFFFF : 16'h0001, 1'b0, 1'b0};
    vecs[2] = '{16'h1234, 4'd0,  1'b0, 16'h1234, 1'b0, 1'b0};
    vecs[3] = '{16'h00F0, 4'd4,  1'b0, 16'h000F, 1'b0, 1'b0};
    vecs[4] = '{16'hFFFF, 4'd1,  1'b1, ARITH ? 16'hFFFF : 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h00B6, 4'd3,  1'b0, 16'h0016, 1'b1, 1'b1};
    vecs[6] = '{16'h8005, 4'd2,  1'b1, ARITH ? 16'hE001 : 16'h2001, 1'b0, 1'b1};
    vecs[7] = '{16'h7FFF, 4'd15, 1'b1, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{16'h0001, 4'd15, 1'b0, 16'h0000, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    check("reset shift_out", {16'd0, shift_out}, 32'd0);
    check("reset flags", {27'd0, carry_out, sticky_out, busy, done, 1'b0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Start re-pulsed mid-SHIFT must be ignored.
    @(negedge clk);
    drive_start(16'h00F0, 4'd4, 1'b0);
    @(negedge clk);
    check("restart busy", {31'd0, busy}, 32'd1);
    drive_start(16'hFFFF, 4'd2, 1'b1);
    @(negedge clk);
    SH_START = 1'b0;
    pulses = 0;
    got = '0;
    cyc = 0;
    for (int c = 2; c < 14; c++) begin
      if (done) begin
        pulses++;
        got = shift_out;
        cyc = c;
      end
      @(negedge clk);
    end
    check("restart pulses", pulses, 1);
    check("restart latency", cyc, 5);
    check("restart shift_out", {16'd0, got}, 32'h000F);
    check("restart carry_sticky", {30'd0, carry_out, sticky_out}, 32'd0);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    drive_start(16'hAAAA, 4'd8, 1'b0);
    @(negedge clk);
    SH_START = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort shift_out", {16'd0, shift_out}, 32'd0);
    check("abort flags", {28'd0, carry_out, sticky_out, busy, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check("abort idle", pulses, 0);
    run_op("post_reset", '{16'h0005, 4'd2, 1'b0, 16'h0001, 1'b0, 1'b1});

    // Back-to-back: second start accepted in the done cycle.
    @(negedge clk);
    drive_start(16'h0003, 4'd1, 1'b0);
    wait_done(cyc, bc, ov);
    check("b2b1 latency", cyc, 2);
    check("b2b1 shift_out", {16'd0, shift_out}, 32'h0001);
    check("b2b1 carry", {31'd0, carry_out}, 32'd1);
    drive_start(16'h0010, 4'd2, 1'b0);
    wait_done(cyc, bc, ov);
    check("b2b2 latency", cyc, 3);
    check("b2b2 busy_cycles", bc, 2);
    check("b2b2 shift_out", {16'd0, shift_out}, 32'h0004);
    check("b2b2 carry_sticky", {30'd0, carry_out, sticky_out}, 32'd0);
    @(negedge clk);
    check("b2b2 done_single", {31'd0, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
